// File: rtl/conbus_arb2.sv
// Two-master / one-slave Wishbone arbiter: round-robin grant locked for a whole cyc.
// Optional slave no-ack watchdog enabled by defining CONBUS_ARB_TIMEOUT_EN.
module conbus_arb2 #(
  parameter int unsigned TIMEOUT = 16
) (
  input  logic        sys_clk,
  input  logic        sys_rst_n,
  input  logic [31:0] m0_adr_i,
  input  logic [31:0] m0_dat_i,
  output logic [31:0] m0_dat_o,
  input  logic [3:0]  m0_sel_i,
  input  logic        m0_cyc_i,
  input  logic        m0_stb_i,
  input  logic        m0_we_i,
  output logic        m0_ack_o,
  output logic        m0_err_o,
  input  logic [31:0] m1_adr_i,
  input  logic [31:0] m1_dat_i,
  output logic [31:0] m1_dat_o,
  input  logic [3:0]  m1_sel_i,
  input  logic        m1_cyc_i,
  input  logic        m1_stb_i,
  input  logic        m1_we_i,
  output logic        m1_ack_o,
  output logic        m1_err_o,
  output logic [31:0] s_adr_o,
  output logic [31:0] s_dat_o,
  input  logic [31:0] s_dat_i,
  output logic [3:0]  s_sel_o,
  output logic        s_cyc_o,
  output logic        s_stb_o,
  output logic        s_we_o,
  input  logic        s_ack_i
);

  localparam logic [1:0] OWN_NONE = 2'd0;
  localparam logic [1:0] OWN_M0   = 2'd1;
  localparam logic [1:0] OWN_M1   = 2'd2;

  if (TIMEOUT < 2 || TIMEOUT > 255) begin : g_bad_timeout
    $error("conbus_arb2: TIMEOUT must be within 2..255");
  end

  logic [1:0] owner;
  logic [1:0] owner_nxt;
  logic       last;       // 1: master 1 was granted most recently
  logic       cyc_mux;
  logic       stb_mux;
  logic       timeout;

  // Grants only leave NONE; an owner always passes through NONE before the next grant.
  always_comb begin
    owner_nxt = owner;
    case (owner)
      OWN_NONE: begin
        if (m0_cyc_i && m1_cyc_i) owner_nxt = last ? OWN_M0 : OWN_M1;
        else if (m0_cyc_i)        owner_nxt = OWN_M0;
        else if (m1_cyc_i)        owner_nxt = OWN_M1;
      end
      OWN_M0:  if (!m0_cyc_i) owner_nxt = OWN_NONE;
      OWN_M1:  if (!m1_cyc_i) owner_nxt = OWN_NONE;
      default: owner_nxt = OWN_NONE;
    endcase
  end

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      owner <= OWN_NONE;
      last  <= 1'b1;
    end else begin
      owner <= owner_nxt;
      if (owner == OWN_NONE && owner_nxt != OWN_NONE)
        last <= (owner_nxt == OWN_M1);
    end
  end

  always_comb begin
    s_adr_o = '0;
    s_dat_o = '0;
    s_sel_o = '0;
    s_we_o  = 1'b0;
    cyc_mux = 1'b0;
    stb_mux = 1'b0;
    case (owner)
      OWN_M0: begin
        s_adr_o = m0_adr_i;
        s_dat_o = m0_dat_i;
        s_sel_o = m0_sel_i;
        s_we_o  = m0_we_i;
        cyc_mux = m0_cyc_i;
        stb_mux = m0_stb_i;
      end
      OWN_M1: begin
        s_adr_o = m1_adr_i;
        s_dat_o = m1_dat_i;
        s_sel_o = m1_sel_i;
        s_we_o  = m1_we_i;
        cyc_mux = m1_cyc_i;
        stb_mux = m1_stb_i;
      end
      default: ;
    endcase
  end

  assign s_cyc_o  = cyc_mux;
  assign s_stb_o  = stb_mux & ~timeout;
  assign m0_ack_o = s_ack_i & (owner == OWN_M0);
  assign m1_ack_o = s_ack_i & (owner == OWN_M1);
  assign m0_dat_o = s_dat_i;
  assign m1_dat_o = s_dat_i;

`ifdef CONBUS_ARB_TIMEOUT_EN
  localparam logic [7:0] WD_LAST = 8'(TIMEOUT - 1);

  logic [7:0] wd_cnt;

  // Ack in the limit cycle wins over the timeout.
  assign timeout  = cyc_mux & stb_mux & ~s_ack_i & (wd_cnt == WD_LAST);
  assign m0_err_o = timeout & (owner == OWN_M0);
  assign m1_err_o = timeout & (owner == OWN_M1);

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n)
      wd_cnt <= '0;
    else if (timeout || s_ack_i || !stb_mux || owner_nxt != owner)
      wd_cnt <= '0;
    else if (cyc_mux)
      wd_cnt <= wd_cnt + 8'd1;
  end
`else
  assign timeout  = 1'b0;
  assign m0_err_o = 1'b0;
  assign m1_err_o = 1'b0;
`endif

endmodule

// File: tb/tb_conbus_arb2.sv
// Bench for conbus_arb2: directed scenarios with literal expectations plus a
// randomized run checked every cycle against a behavioural arbiter model.
module tb_conbus_arb2;

  localparam int unsigned TO_LIMIT = 16;

  logic        sys_clk = 1'b0;
  logic        sys_rst_n = 1'b0;
  logic [31:0] m0_adr_i = '0, m0_dat_i = '0, m1_adr_i = '0, m1_dat_i = '0;
  logic [3:0]  m0_sel_i = '0, m1_sel_i = '0;
  logic        m0_cyc_i = 1'b0, m0_stb_i = 1'b0, m0_we_i = 1'b0;
  logic        m1_cyc_i = 1'b0, m1_stb_i = 1'b0, m1_we_i = 1'b0;
  logic [31:0] s_dat_i = '0;
  logic        s_ack_i = 1'b0;
  logic [31:0] m0_dat_o, m1_dat_o, s_adr_o, s_dat_o;
  logic [3:0]  s_sel_o;
  logic        m0_ack_o, m0_err_o, m1_ack_o, m1_err_o, s_cyc_o, s_stb_o, s_we_o;

  always #5 sys_clk = ~sys_clk;

  conbus_arb2 #(.TIMEOUT(TO_LIMIT)) dut (
    .sys_clk(sys_clk), .sys_rst_n(sys_rst_n),
    .m0_adr_i(m0_adr_i), .m0_dat_i(m0_dat_i), .m0_dat_o(m0_dat_o), .m0_sel_i(m0_sel_i),
    .m0_cyc_i(m0_cyc_i), .m0_stb_i(m0_stb_i), .m0_we_i(m0_we_i),
    .m0_ack_o(m0_ack_o), .m0_err_o(m0_err_o),
    .m1_adr_i(m1_adr_i), .m1_dat_i(m1_dat_i), .m1_dat_o(m1_dat_o), .m1_sel_i(m1_sel_i),
    .m1_cyc_i(m1_cyc_i), .m1_stb_i(m1_stb_i), .m1_we_i(m1_we_i),
    .m1_ack_o(m1_ack_o), .m1_err_o(m1_err_o),
    .s_adr_o(s_adr_o), .s_dat_o(s_dat_o), .s_dat_i(s_dat_i), .s_sel_o(s_sel_o),
    .s_cyc_o(s_cyc_o), .s_stb_o(s_stb_o), .s_we_o(s_we_o), .s_ack_i(s_ack_i)
  );

  int total = 0;
  int bad = 0;

  task automatic check(input string name, input logic [159:0] got, input logic [159:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h at t=%0t", name, got, exp, $time);
    end
  endtask

  // Model: mo = 0 none / 1 master0 / 2 master1; ml = last granted master; wd = stalled strobe cycles.
  int mo = 0;
  int ml = 2;
  int wd = 0;

  function automatic logic model_timeout(input int own, input int cnt);
    logic c, s;
    c = (own == 1) ? m0_cyc_i : (own == 2) ? m1_cyc_i : 1'b0;
    s = (own == 1) ? m0_stb_i : (own == 2) ? m1_stb_i : 1'b0;
`ifdef CONBUS_ARB_TIMEOUT_EN
    return c && s && !s_ack_i && (cnt == int'(TO_LIMIT) - 1);
`else
    return 1'b0 & c & s & (cnt < 0);
`endif
  endfunction

  always @(posedge sys_clk or negedge sys_rst_n) begin : model
    int nxt;
    logic s;
    logic to;
    if (!sys_rst_n) begin
      mo = 0;
      ml = 2;
      wd = 0;
    end else begin
      to = model_timeout(mo, wd);
      s  = (mo == 1) ? m0_stb_i : (mo == 2) ? m1_stb_i : 1'b0;
      if (mo == 0) begin
        if (m0_cyc_i && m1_cyc_i) nxt = (ml == 1) ? 2 : 1;
        else if (m0_cyc_i)        nxt = 1;
        else if (m1_cyc_i)        nxt = 2;
        else                      nxt = 0;
        if (nxt != 0) ml = nxt;
      end else if (mo == 1) nxt = m0_cyc_i ? 1 : 0;
      else                  nxt = m1_cyc_i ? 2 : 0;
      if (to || s_ack_i || !s || nxt != mo) wd = 0;
      else wd = wd + 1;
      mo = nxt;
    end
  end

  function automatic logic [138:0] exp_vec();
    logic [31:0] a, d;
    logic [3:0]  sl;
    logic        c, s, w, to;
    a = '0; d = '0; sl = '0; c = 1'b0; s = 1'b0; w = 1'b0;
    if (mo == 1) begin
      a = m0_adr_i; d = m0_dat_i; sl = m0_sel_i; c = m0_cyc_i; s = m0_stb_i; w = m0_we_i;
    end else if (mo == 2) begin
      a = m1_adr_i; d = m1_dat_i; sl = m1_sel_i; c = m1_cyc_i; s = m1_stb_i; w = m1_we_i;
    end
    to = model_timeout(mo, wd);
    return {a, d, sl, c, s & ~to, w,
            s_ack_i && mo == 1, s_ack_i && mo == 2, to && mo == 1, to && mo == 2,
            s_dat_i, s_dat_i};
  endfunction

  logic [138:0] dut_vec;
  assign dut_vec = {s_adr_o, s_dat_o, s_sel_o, s_cyc_o, s_stb_o, s_we_o,
                    m0_ack_o, m1_ack_o, m0_err_o, m1_err_o, m0_dat_o, m1_dat_o};

  always @(negedge sys_clk) check("outputs_vs_model", dut_vec, exp_vec());

  task automatic tick();
    @(posedge sys_clk);
    #1;
  endtask

  task automatic neg();
    @(negedge sys_clk);
  endtask

  task automatic idle_all();
    m0_cyc_i = 1'b0; m0_stb_i = 1'b0; m0_we_i = 1'b0; m0_adr_i = '0; m0_dat_i = '0; m0_sel_i = '0;
    m1_cyc_i = 1'b0; m1_stb_i = 1'b0; m1_we_i = 1'b0; m1_adr_i = '0; m1_dat_i = '0; m1_sel_i = '0;
    s_ack_i = 1'b0; s_dat_i = '0;
  endtask

  task automatic pulse_reset();
    sys_rst_n = 1'b0;
    tick();
    sys_rst_n = 1'b1;
  endtask

  task automatic m0_req(input logic [31:0] adr);
    m0_cyc_i = 1'b1; m0_stb_i = 1'b1; m0_adr_i = adr; m0_sel_i = 4'hF;
  endtask

  task automatic m1_req(input logic [31:0] adr);
    m1_cyc_i = 1'b1; m1_stb_i = 1'b1; m1_adr_i = adr; m1_sel_i = 4'hF;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL global_time_limit reached t=%0t required=finish", $time);
    $fatal(1, "time limit");
  end

  initial begin
    idle_all();
    tick(); tick();
    neg();
    check("reset_s_cyc_stb_we", {s_cyc_o, s_stb_o, s_we_o}, 3'b000);
    check("reset_s_adr_dat_sel", {s_adr_o, s_dat_o, s_sel_o}, 68'h0);
    check("reset_ack_err", {m0_ack_o, m1_ack_o, m0_err_o, m1_err_o}, 4'b0000);
    tick();
    sys_rst_n = 1'b1;

    // Single read by master 0, slave acks 3 cycles after it first sees stb.
    tick();
    m0_req(32'h6000_0000);
    neg(); check("t1_bubble_s_cyc", s_cyc_o, 1'b0);
    tick();
    neg(); check("t1_granted_s_cyc", s_cyc_o, 1'b1);
    check("t1_s_adr", s_adr_o, 32'h6000_0000);
    tick(); tick(); tick();
    s_ack_i = 1'b1; s_dat_i = 32'hCAFE_F00D;
    neg(); check("t1_m0_ack", m0_ack_o, 1'b1);
    check("t1_m0_dat", m0_dat_o, 32'hCAFE_F00D);
    check("t1_m1_ack", m1_ack_o, 1'b0);
    tick(); idle_all();
    neg(); check("t1_ack_single", m0_ack_o, 1'b0);
    tick();

    // Tie straight after reset: master 0 first, master 1 two edges after release.
    pulse_reset();
    m0_req(32'h100); m1_req(32'h200);
    tick();
    neg(); check("t2_first_owner_adr", s_adr_o, 32'h100);
    tick(); tick();
    m0_cyc_i = 1'b0; m0_stb_i = 1'b0;
    neg(); check("t2_drop_same_cycle", s_cyc_o, 1'b0);
    tick();
    neg(); check("t2_bubble", s_cyc_o, 1'b0);
    tick();
    neg(); check("t2_m1_granted_adr", s_adr_o, 32'h200);
    check("t2_m1_granted_cyc", s_cyc_o, 1'b1);
    tick(); m1_cyc_i = 1'b0; m1_stb_i = 1'b0;
    tick(); tick();
    m0_req(32'h100); m1_req(32'h200);
    tick();
    neg(); check("t2_repeat_m0_first", s_adr_o, 32'h100);
    tick(); idle_all();
    tick(); tick();

    // Locked burst by master 1 while master 0 waits.
    m1_req(32'h300); m1_we_i = 1'b1; m1_dat_i = 32'd1;
    tick();
    m0_req(32'h400);
    s_ack_i = 1'b1;
    for (int k = 1; k <= 4; k++) begin
      m1_dat_i = 32'(k);
      neg();
      check("t3_beat_dat", s_dat_o, 32'(k));
      check("t3_beat_we_ack", {s_we_o, m1_ack_o, m0_ack_o}, 3'b110);
      tick();
    end
    m1_cyc_i = 1'b0; m1_stb_i = 1'b0; m1_we_i = 1'b0; s_ack_i = 1'b0;
    neg(); check("t3_release_cyc", s_cyc_o, 1'b0);
    tick();
    neg(); check("t3_bubble", s_cyc_o, 1'b0);
    tick();
    neg(); check("t3_m0_after_burst", s_adr_o, 32'h400);
    tick(); idle_all();
    tick(); tick();

    // Abort before ack: a late ack goes to nobody.
    m0_req(32'h500);
    tick(); tick();
    m0_cyc_i = 1'b0; m0_stb_i = 1'b0;
    neg(); check("t4_abort_s_cyc", s_cyc_o, 1'b0);
    tick();
    s_ack_i = 1'b1;
    neg(); check("t4_late_ack_nobody", {m0_ack_o, m1_ack_o}, 2'b00);
    tick(); idle_all();
    tick();

    // Asynchronous reset mid-transfer.
    m1_req(32'h600); m1_we_i = 1'b1;
    tick();
    neg(); check("t5_owner_cyc", s_cyc_o, 1'b1);
    #2 sys_rst_n = 1'b0;
    #1 check("t5_async_s_cyc", s_cyc_o, 1'b0);
    check("t5_async_outputs", {s_adr_o, s_stb_o, s_we_o, m1_ack_o}, 35'h0);
    idle_all();
    tick();
    sys_rst_n = 1'b1;
    tick();

`ifdef CONBUS_ARB_TIMEOUT_EN
    // Hung slave: error in the 16th strobe cycle with strobe masked.
    m0_req(32'h700);
    tick();
    for (int i = 1; i <= 16; i++) begin
      neg();
      if (i < 16) check("wd_stall_stb_err", {s_stb_o, m0_err_o}, 2'b10);
      else        check("wd_timeout_stb_err_ack", {s_stb_o, m0_err_o, m0_ack_o}, 3'b010);
      tick();
    end
    idle_all();
    tick(); tick();
    // Ack exactly in the limit cycle beats the error.
    m0_req(32'h704);
    tick();
    for (int i = 1; i <= 16; i++) begin
      if (i == 16) s_ack_i = 1'b1;
      neg();
      if (i == 16) check("wd_ack_wins", {s_stb_o, m0_err_o, m0_ack_o}, 3'b101);
      tick();
    end
    idle_all();
    tick(); tick();
`endif

    // Random traffic; slow-slave segments exercise long stalls.
    for (int n = 0; n < 4000; n++) begin
      automatic int ack_pct = ((n / 500) % 2 == 1) ? 3 : 35;
      if (m0_cyc_i) begin
        if ($urandom_range(0, 7) == 0) m0_cyc_i = 1'b0;
      end else if ($urandom_range(0, 3) == 0) m0_cyc_i = 1'b1;
      if (m1_cyc_i) begin
        if ($urandom_range(0, 7) == 0) m1_cyc_i = 1'b0;
      end else if ($urandom_range(0, 3) == 0) m1_cyc_i = 1'b1;
      m0_stb_i = m0_cyc_i & ($urandom_range(0, 3) != 0);
      m1_stb_i = m1_cyc_i & ($urandom_range(0, 3) != 0);
      m0_we_i = 1'($urandom()); m1_we_i = 1'($urandom());
      m0_adr_i = $urandom(); m1_adr_i = $urandom();
      m0_dat_i = $urandom(); m1_dat_i = $urandom();
      m0_sel_i = 4'($urandom()); m1_sel_i = 4'($urandom());
      s_dat_i = $urandom();
      s_ack_i = ($urandom_range(0, 99) < ack_pct);
      tick();
    end
    idle_all();
    tick(); tick();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
